adc_ctrl: RTL and testbench
===========================

// Module: adc_ctrl
// PURPOSE
//  Serial-interface master for a 12-bit SPI-style ADC (AD7476/ADCS7476 class).
//  On a start request it drives sync (active-low CS) and a divided sclk, shifts in a
//  16-bit frame from sdo (4 leading zeros + 12 data bits, MSB first), and presents
//  the 12-bit sample on data with a one-cycle ready strobe. Sits between the board
//  ADC pins and the sample-consuming logic.
// PARAMETERS
//  CLK_DIV      4   clk_in cycles per sclk period (even, >=2); 50 MHz in -> 12.5 MHz sclk
//  FRAME_BITS   16  sclk cycles per conversion frame
//  DATA_BITS    12  width of data; last DATA_BITS bits of the frame are kept
//  QUIET_CYC    4   clk_in cycles with sync high between frames (t_quiet)
// PORTS
//  clk_in  in   1   system clock, all logic on rising edge
//  rst_n   in   1   reset, asynchronous, active-low
//  ctrl    in   1   start request; rising edge (registered edge detect) starts a frame
//  sdo     in   1   ADC serial data out
//  n       in   1   mode: 0 = single conversion per ctrl edge, 1 = continuous
//  data    out  12  last completed sample, held until next frame completes
//  sync    out  1   ADC chip select, active-low
//  sclk    out  1   ADC serial clock, idles high
//  ready   out  1   one clk_in-cycle pulse when data updates
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, sync=1, sclk=1, data=0, ready=0, shift reg=0,
//   ctrl edge-detect flop=0. Reset mid-frame aborts immediately; no ready produced.
//  FSM states: IDLE, START, SHIFT, DONE, QUIET.
//  IDLE: sync=1, sclk=1. ctrl=1 with ctrl_q=0 at an edge (cycle 0) -> START, sync<=0.
//  START: one cycle (CS setup), sclk=1 -> SHIFT with bit counter=0, phase=0.
//  SHIFT: phase counter 0..CLK_DIV-1; sclk=0 for phases 0..CLK_DIV/2-1, 1 otherwise.
//   sdo sampled into LSB of shift reg (shift left) on the edge where sclk goes 0->1.
//   After FRAME_BITS samples (FRAME_BITS*CLK_DIV = 64 cycles) -> DONE, sclk=1.
//  DONE: sync<=1, data<=shift[DATA_BITS-1:0], ready=1 for exactly this one cycle.
//   With defaults ready is high at cycle 66 after the detecting edge (cycle 0).
//  QUIET: sync=1, sclk=1 for QUIET_CYC cycles. Then n sampled: n=1 -> START
//   (auto-restart, no ctrl needed); n=0 -> IDLE.
//  ctrl edges outside IDLE are ignored (not queued). ctrl held high does not retrigger;
//   a new rising edge is required. Change of n takes effect only at end of QUIET.
//  Leading 4 frame bits are discarded regardless of value.
//  data and ready are registered outputs; sync, sclk registered (glitch-free).
// STRUCTURE
//  Shared package: state enum, CLK_DIV/FRAME_BITS/DATA_BITS/QUIET_CYC defaults.
//  Single module; optional sub-module sclk_gen (phase counter + sclk/rise strobe).
// TESTING
//  1 sdo held 1, n=0, ctrl pulse 35 ns -> 16 sclk periods of 80 ns, sync low ~1.3 us,
//    data=12'hFFF, one ready pulse at cycle 66, then IDLE with sync=sclk=1.
//  2 ADC model drives 16'h0A5C on sclk falling edges -> data=12'hA5C; pattern
//    16'h0555 -> 12'h555 (checks MSB-first order and leading-bit discard).
//  3 n=1 after one ctrl edge -> back-to-back frames every 70 cycles, ready each frame;
//    drop n=0 mid-frame -> current frame completes, then IDLE.
//  4 second ctrl pulse during SHIFT -> ignored; exactly one ready; no frame restart.
//  5 rst_n low at bit 7 -> sync=1, sclk=1, ready=0, data=0 immediately; new ctrl edge
//    after release runs a full clean frame.
//  6 ctrl held high across frame end with n=0 -> no second frame until ctrl re-rises.

Source files
------------

// File: rtl/adc_ctrl_pkg.sv
// adc_ctrl_pkg
//   Shared definitions for the AD7476-class ADC serial master: FSM state
//   encoding and the default frame timing parameters.
`timescale 1ns/1ps
package adc_ctrl_pkg;

    localparam int DEF_CLK_DIV    = 4;   // clk_in cycles per sclk period (even, >= 2)
    localparam int DEF_FRAME_BITS = 16;  // sclk cycles per conversion frame
    localparam int DEF_DATA_BITS  = 12;  // trailing frame bits kept as the sample
    localparam int DEF_QUIET_CYC  = 4;   // clk_in cycles with sync high between frames

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_QUIET = 3'd4
    } state_t;

endpackage

// File: rtl/adc_ctrl_sclk_gen.sv
// adc_ctrl_sclk_gen
//   Phase counter and registered sclk for the SHIFT state.
//   Ports:
//     clk_in, rst_n : clock / async active-low reset
//     en            : FSM currently in SHIFT (phase counter runs)
//     en_next       : FSM will be in SHIFT next cycle (drives next sclk level)
//     sclk          : registered serial clock, idles high
//     rise          : strobe, the coming edge takes sclk 0->1 (sample sdo)
//     wrap          : strobe, last phase of the current sclk period
`timescale 1ns/1ps
module adc_ctrl_sclk_gen
    import adc_ctrl_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic en,
    input  logic en_next,
    output logic sclk,
    output logic rise,
    output logic wrap
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] LAST    = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] HALF    = PW'(CLK_DIV / 2);
    localparam logic [PW-1:0] HALF_M1 = PW'(CLK_DIV / 2 - 1);

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_next;

    always_comb begin
        phase_next = '0;
        if (en && (phase != LAST))
            phase_next = phase + PW'(1);
    end

    // sclk is registered from the next phase so its level always matches the
    // phase register: low for the first half of each period, high otherwise.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
            sclk  <= 1'b1;
        end else begin
            phase <= phase_next;
            sclk  <= en_next ? (phase_next >= HALF) : 1'b1;
        end
    end

    assign rise = en && (phase == HALF_M1);
    assign wrap = en && (phase == LAST);

endmodule

// File: rtl/adc_ctrl.sv
// adc_ctrl
//   Serial master for a 12-bit SPI-style ADC. A rising edge on ctrl (or the
//   end of the quiet gap in continuous mode) runs one frame: sync low, 16 sclk
//   periods, sdo shifted in MSB first, the trailing DATA_BITS bits presented on
//   data with a one-cycle ready pulse.
//   Ports:
//     clk_in, rst_n : clock / async active-low reset
//     ctrl          : start request, rising edge starts a frame from IDLE
//     sdo           : ADC serial data
//     n             : 0 = single conversion, 1 = continuous
//     data          : last completed sample (held)
//     sync          : ADC chip select, active-low
//     sclk          : ADC serial clock, idles high
//     ready         : one-cycle pulse when data updates
`timescale 1ns/1ps
module adc_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int QUIET_CYC  = DEF_QUIET_CYC
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 ctrl,
    input  logic                 sdo,
    input  logic                 n,
    output logic [DATA_BITS-1:0] data,
    output logic                 sync,
    output logic                 sclk,
    output logic                 ready
);

    localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int QW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

    state_t               state;
    state_t               state_next;
    logic                 ctrl_q;
    logic                 start_edge;
    logic [BW-1:0]        bit_cnt;
    logic [QW-1:0]        quiet_cnt;
    // Only the trailing DATA_BITS are kept; leading frame bits fall off the top.
    logic [DATA_BITS-1:0] shift;
    logic                 rise;
    logic                 wrap;
    logic                 last_bit;
    logic                 quiet_end;
    logic                 sync_d;
    logic                 ready_d;
    logic                 load_data;

    assign start_edge = ctrl & ~ctrl_q;
    assign last_bit   = wrap && (bit_cnt == BW'(FRAME_BITS - 1));
    assign quiet_end  = (state == ST_QUIET) && (quiet_cnt == QW'(QUIET_CYC - 1));

    adc_ctrl_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (state == ST_SHIFT),
        .en_next (state_next == ST_SHIFT),
        .sclk    (sclk),
        .rise    (rise),
        .wrap    (wrap)
    );

    // State register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start_edge) state_next = ST_START;
            ST_START: state_next = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_next = ST_DONE;
            ST_DONE:  state_next = ST_QUIET;
            ST_QUIET: if (quiet_end) state_next = n ? ST_START : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output decode; the values are registered below so pins stay glitch-free.
    always_comb begin
        sync_d    = 1'b1;
        ready_d   = 1'b0;
        load_data = 1'b0;
        if ((state_next == ST_START) || (state_next == ST_SHIFT) || (state_next == ST_DONE))
            sync_d = 1'b0;
        if (state == ST_DONE) begin
            ready_d   = 1'b1;
            load_data = 1'b1;
        end
    end

    // Datapath: edge detect, bit/quiet counters, shift register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= 1'b0;
            bit_cnt   <= '0;
            quiet_cnt <= '0;
            shift     <= '0;
        end else begin
            // Runs in every state, so edges seen outside IDLE are consumed.
            ctrl_q <= ctrl;

            if (state == ST_START)
                bit_cnt <= '0;
            else if (wrap)
                bit_cnt <= bit_cnt + BW'(1);

            if (state == ST_QUIET)
                quiet_cnt <= quiet_cnt + QW'(1);
            else
                quiet_cnt <= '0;

            if (state == ST_START)
                shift <= '0;
            else if (rise)
                shift <= {shift[DATA_BITS-2:0], sdo};
        end
    end

    // Registered outputs
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 1'b1;
            ready <= 1'b0;
            data  <= '0;
        end else begin
            sync  <= sync_d;
            ready <= ready_d;
            if (load_data)
                data <= shift;
        end
    end

endmodule

// File: tb/tb_adc_ctrl.sv
`timescale 1ns/1ps
module tb_adc_ctrl;

    localparam int T_CLK = 20;  // 50 MHz

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        ctrl;
    logic        sdo = 1'b1;
    logic        n;
    logic [11:0] data;
    logic        sync;
    logic        sclk;
    logic        ready;

    adc_ctrl dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .ctrl   (ctrl),
        .sdo    (sdo),
        .n      (n),
        .data   (data),
        .sync   (sync),
        .sclk   (sclk),
        .ready  (ready)
    );

    always #(T_CLK/2) clk_in = ~clk_in;

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int ready_cnt = 0;
    int ready_cyc = 0;
    int t0        = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ADC model: a frame word is taken when sync falls, one bit per sclk falling
    // edge, MSB first. The expected sample is the word's trailing 12 bits.
    logic [15:0] adc_q[$];
    logic [11:0] exp_q[$];
    logic [15:0] cur_word = 16'h0;
    int          bit_idx  = -1;
    time         rise_t[$];
    time         sync_fall_t = 0;
    time         sync_rise_t = 0;

    always @(negedge sync) begin
        cur_word = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0;
        exp_q.push_back(cur_word[11:0]);
        bit_idx = 15;
        sync_fall_t = $time;
    end

    always @(posedge sync) sync_rise_t = $time;

    always @(negedge sclk) begin
        if (sync === 1'b0 && bit_idx >= 0) begin
            sdo = cur_word[bit_idx];
            bit_idx = bit_idx - 1;
        end
    end

    always @(posedge sclk) rise_t.push_back($time);

    // Scoreboard: every ready pulse must deliver the next expected sample.
    always @(negedge clk_in) begin
        if (rst_n === 1'b1 && ready === 1'b1) begin
            ready_cnt++;
            ready_cyc = cyc;
            if (exp_q.size() > 0) chk("sb_data", 32'(data), 32'(exp_q.pop_front()));
            else                  chk("sb_ready_unexpected", 32'(ready), 32'd0);
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk_in);
        #1;
    endtask

    task automatic start_frame(input bit hold);
        ctrl = 1'b1;
        step(1);
        t0 = cyc;
        if (!hold) ctrl = 1'b0;
    endtask

    task automatic wait_ready(input int exp_ofs, input string tag);
        int c0;
        int k;
        c0 = ready_cnt;
        k  = 0;
        while (ready_cnt == c0 && k < 400) begin
            step(1);
            k++;
        end
        chk({tag, "_seen"}, 32'(ready_cnt != c0), 32'd1);
        chk({tag, "_lat"}, 32'(ready_cyc - t0), 32'(exp_ofs));
    endtask

    task automatic chk_sclk(input string tag);
        int bad;
        bad = 0;
        for (int i = 1; i < rise_t.size(); i++)
            if (int'(rise_t[i] - rise_t[i-1]) != 4 * T_CLK) bad++;
        chk({tag, "_rises"}, 32'(rise_t.size()), 32'd16);
        chk({tag, "_period"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int          base;

        rst_n = 1'b0;
        ctrl  = 1'b0;
        n     = 1'b0;
        step(3);
        chk("rst_sync",  32'(sync),  32'd1);
        chk("rst_sclk",  32'(sclk),  32'd1);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_data",  32'(data),  32'd0);
        rst_n = 1'b1;
        step(3);

        // 1: sdo all ones, 35 ns ctrl pulse, single frame
        rise_t.delete();
        adc_q.push_back(16'hFFFF);
        base = ready_cnt;
        ctrl = 1'b1;
        @(posedge clk_in);
        #1;
        t0 = cyc;
        chk("t1_sync_low", 32'(sync), 32'd0);
        chk("t1_sclk_start", 32'(sclk), 32'd1);
        #15 ctrl = 1'b0;
        step(1);
        wait_ready(66, "t1");
        chk("t1_data", 32'(data), 32'h0FFF);
        chk_sclk("t1");
        chk("t1_sync_ns", 32'(int'(sync_rise_t - sync_fall_t)), 32'd1320);
        step(100);
        chk("t1_one_ready", 32'(ready_cnt - base), 32'd1);
        chk("t1_idle_sync", 32'(sync), 32'd1);
        chk("t1_idle_sclk", 32'(sclk), 32'd1);

        // 2: directed and random patterns, single mode
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      w = 16'h0A5C;
            else if (i == 1) w = 16'h0555;
            else             w = 16'($urandom);
            adc_q.push_back(w);
            start_frame(1'b0);
            wait_ready(66, "t2");
            chk("t2_data", 32'(data), 32'(w[11:0]));
            step(10);
        end

        // 3: continuous mode, drop n mid-frame
        n = 1'b1;
        for (int i = 0; i < 4; i++) adc_q.push_back(16'($urandom));
        base = ready_cnt;
        start_frame(1'b0);
        wait_ready(66,  "t3_f1");
        wait_ready(136, "t3_f2");
        wait_ready(206, "t3_f3");
        step(30);
        n = 1'b0;
        wait_ready(276, "t3_f4");
        step(200);
        chk("t3_count", 32'(ready_cnt - base), 32'd4);
        chk("t3_idle_sync", 32'(sync), 32'd1);

        // 4: ctrl pulse during SHIFT is ignored
        adc_q.push_back(16'h0ABC);
        base = ready_cnt;
        start_frame(1'b0);
        step(20);
        ctrl = 1'b1;
        step(2);
        ctrl = 1'b0;
        wait_ready(66, "t4");
        step(150);
        chk("t4_count", 32'(ready_cnt - base), 32'd1);
        chk("t4_data", 32'(data), 32'h0ABC);

        // 5: reset at bit 7 aborts, then a clean frame
        adc_q.push_back(16'h0F0F);
        start_frame(1'b0);
        step(30);
        base = ready_cnt;
        rst_n = 1'b0;
        #1;
        chk("t5_sync",  32'(sync),  32'd1);
        chk("t5_sclk",  32'(sclk),  32'd1);
        chk("t5_ready", 32'(ready), 32'd0);
        chk("t5_data",  32'(data),  32'd0);
        step(3);
        exp_q.delete();
        adc_q.delete();
        rst_n = 1'b1;
        step(3);
        chk("t5_no_ready", 32'(ready_cnt - base), 32'd0);
        rise_t.delete();
        adc_q.push_back(16'h0C3A);
        start_frame(1'b0);
        wait_ready(66, "t5");
        chk("t5_data_after", 32'(data), 32'h0C3A);
        chk_sclk("t5");
        step(10);

        // 6: ctrl held high does not retrigger
        adc_q.push_back(16'h0111);
        adc_q.push_back(16'h0222);
        base = ready_cnt;
        start_frame(1'b1);
        wait_ready(66, "t6a");
        step(150);
        chk("t6_held_count", 32'(ready_cnt - base), 32'd1);
        chk("t6_held_data", 32'(data), 32'h0111);
        ctrl = 1'b0;
        step(2);
        start_frame(1'b0);
        wait_ready(66, "t6b");
        chk("t6_data", 32'(data), 32'h0222);
        step(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
